// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the issue-stage hazard scoreboard.
// Entries store rd at a fixed maximum width so the struct stays parameter-free.
package hazard_scoreboard_pkg;

   localparam int DEF_DEPTH    = 4;
   localparam int DEF_LOAD_LAT = 2;
   localparam int MAX_REG_W    = 8;
   localparam int FWD_RF       = 0;

   typedef struct packed {
      logic                 valid;
      logic [MAX_REG_W-1:0] rd;
      logic                 wr;
      logic                 load;
   } entry_t;

endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// Per-source priority match against the in-flight entries: decides whether the
// source must stall in issue and which forward bus EX should select next cycle.
module hz_src_match
   import hazard_scoreboard_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int LOAD_LAT = DEF_LOAD_LAT,
   parameter int REG_W    = 5,
   parameter int SEL_W    = $clog2(DEPTH)
) (
   input  logic                   use_i,
   input  logic [REG_W-1:0]       idx_i,
   input  entry_t [DEPTH-1:0]     entries_i,
   output logic                   stall_o,
   output logic [SEL_W-1:0]       sel_o
);

   logic                 found;
   logic                 hit_load;
   logic                 active;
   int                   hit_k;
   int                   rdy;
   logic [MAX_REG_W-1:0] idx_ext;

   always_comb begin
      idx_ext  = MAX_REG_W'(idx_i);
      found    = 1'b0;
      hit_k    = 0;
      hit_load = 1'b0;
      // Scan oldest to youngest so the youngest producer overwrites the result.
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (entries_i[k].valid && entries_i[k].wr && (entries_i[k].rd == idx_ext)) begin
            found    = 1'b1;
            hit_k    = k;
            hit_load = entries_i[k].load;
         end
      end
      active  = use_i && (idx_i != '0) && found;
      rdy     = hit_load ? LOAD_LAT : 1;
      stall_o = active && ((hit_k + 1) < rdy);
      sel_o   = SEL_W'(FWD_RF);
      if (active && ((hit_k + 1) <= (DEPTH - 1))) begin
         sel_o = SEL_W'(hit_k + 1);
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage scoreboard: shifts in-flight destinations toward WB, raises the
// issue stall and registers the EX forwarding selects one cycle after issue.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int REG_W    = 5,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int LOAD_LAT = DEF_LOAD_LAT,
   parameter int SEL_W    = $clog2(DEPTH),
   parameter int CNT_W    = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        iss_valid_i,
   input  logic [REG_W-1:0]            iss_rs_i,
   input  logic [REG_W-1:0]            iss_rt_i,
   input  logic                        iss_use_rs_i,
   input  logic                        iss_use_rt_i,
   input  logic [REG_W-1:0]            iss_rd_i,
   input  logic                        iss_reg_wr_i,
   input  logic                        iss_is_load_i,
   input  logic                        flush_i,
   output logic                        stall_iss_o,
   output logic                        ex_valid_o,
   output logic [SEL_W-1:0]            fwd_p1_ex_o,
   output logic [SEL_W-1:0]            fwd_p2_ex_o,
   output logic [$clog2(DEPTH+1)-1:0]  inflight_cnt_o,
   output logic [CNT_W-1:0]            stall_cnt_o
);

   localparam int INF_W = $clog2(DEPTH + 1);

   entry_t [DEPTH-1:0] ent_q, ent_d;
   entry_t             head;
   logic               ex_valid_q, ex_valid_d;
   logic [SEL_W-1:0]   fwd1_q, fwd1_d, fwd2_q, fwd2_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [INF_W-1:0]   inflight;
   logic               stall1, stall2, push;
   logic [SEL_W-1:0]   sel1, sel2;

   hz_src_match #(
      .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .REG_W(REG_W), .SEL_W(SEL_W)
   ) u_match_rs (
      .use_i(iss_use_rs_i), .idx_i(iss_rs_i), .entries_i(ent_q),
      .stall_o(stall1), .sel_o(sel1)
   );

   hz_src_match #(
      .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .REG_W(REG_W), .SEL_W(SEL_W)
   ) u_match_rt (
      .use_i(iss_use_rt_i), .idx_i(iss_rt_i), .entries_i(ent_q),
      .stall_o(stall2), .sel_o(sel2)
   );

   assign stall_iss_o = iss_valid_i & ~flush_i & (stall1 | stall2);
   assign push        = iss_valid_i & ~stall_iss_o & ~flush_i;

   always_comb begin
      head = '0;
      if (push) begin
         head.valid = 1'b1;
         head.rd    = MAX_REG_W'(iss_rd_i);
         // Writes to r0 (or beyond the register file) never create a hazard.
         head.wr    = iss_reg_wr_i && (iss_rd_i != '0) && (int'(iss_rd_i) < NUM_REGS);
         head.load  = iss_is_load_i;
      end
      ent_d       = {ent_q[DEPTH-2:0], head};
      ex_valid_d  = push;
      fwd1_d      = push ? sel1 : SEL_W'(FWD_RF);
      fwd2_d      = push ? sel2 : SEL_W'(FWD_RF);
      stall_cnt_d = (stall_iss_o && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   end

   always_comb begin
      inflight = '0;
      for (int k = 0; k < DEPTH; k++) begin
         inflight = inflight + INF_W'(ent_q[k].valid);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ent_q       <= '0;
         ex_valid_q  <= 1'b0;
         fwd1_q      <= '0;
         fwd2_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         ent_q       <= ent_d;
         ex_valid_q  <= ex_valid_d;
         fwd1_q      <= fwd1_d;
         fwd2_q      <= fwd2_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ex_valid_o     = ex_valid_q;
   assign fwd_p1_ex_o    = fwd1_q;
   assign fwd_p2_ex_o    = fwd2_q;
   assign inflight_cnt_o = inflight;
   assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=4, LOAD_LAT=2): issue-side
// stimulus queues expected EX selects, a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

   logic       clk;
   logic       reset;
   logic       iss_valid, iss_use_rs, iss_use_rt, iss_reg_wr, iss_is_load, flush;
   logic [4:0] iss_rs, iss_rt, iss_rd;
   logic       stall_iss_o, ex_valid_o;
   logic [1:0] fwd_p1_ex_o, fwd_p2_ex_o;
   logic [2:0] inflight_cnt_o;
   logic [15:0] stall_cnt_o;

   typedef struct {
      string tag;
      int    f1;
      int    f2;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   hazard_scoreboard dut (
      .clk(clk), .reset(reset),
      .iss_valid_i(iss_valid), .iss_rs_i(iss_rs), .iss_rt_i(iss_rt),
      .iss_use_rs_i(iss_use_rs), .iss_use_rt_i(iss_use_rt),
      .iss_rd_i(iss_rd), .iss_reg_wr_i(iss_reg_wr), .iss_is_load_i(iss_is_load),
      .flush_i(flush),
      .stall_iss_o(stall_iss_o), .ex_valid_o(ex_valid_o),
      .fwd_p1_ex_o(fwd_p1_ex_o), .fwd_p2_ex_o(fwd_p2_ex_o),
      .inflight_cnt_o(inflight_cnt_o), .stall_cnt_o(stall_cnt_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every EX cycle with a real instruction consumes one expectation.
   always @(negedge clk) begin
      if (reset && ex_valid_o) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ex: ex_valid_o=1 with no issued instruction pending");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, " fwd_p1"}, int'(fwd_p1_ex_o), e.f1);
            chk({e.tag, " fwd_p2"}, int'(fwd_p2_ex_o), e.f2);
            $display("ex  %s p1=%0d p2=%0d", e.tag, fwd_p1_ex_o, fwd_p2_ex_o);
         end
      end
   end

   task automatic nop(input int n);
      iss_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; holds the instruction until it leaves issue.
   task automatic issue(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic wr, input logic ld, input int e1, input int e2,
                        input int exp_stalls);
      exp_t e;
      int   stalls;
      bit   done;
      iss_valid = 1'b1; iss_rs = rs; iss_rt = rt; iss_use_rs = urs; iss_use_rt = urt;
      iss_rd = rd; iss_reg_wr = wr; iss_is_load = ld; flush = 1'b0;
      e.tag = tag; e.f1 = e1; e.f2 = e2;
      exp_q.push_back(e);
      stalls = 0;
      done   = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         @(negedge clk);
         if (stall_iss_o) begin
            stalls++;
         end else begin
            if (stalls > 0) chk({tag, " bubble ex_valid"}, int'(ex_valid_o), 0);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) chk({tag, " issue timeout"}, 1, 0);
      chk({tag, " stall cycles"}, stalls, exp_stalls);
      $display("iss %s stalls=%0d", tag, stalls);
      iss_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; iss_valid = 1'b0; iss_rs = '0; iss_rt = '0; iss_use_rs = 1'b0;
      iss_use_rt = 1'b0; iss_rd = '0; iss_reg_wr = 1'b0; iss_is_load = 1'b0; flush = 1'b0;
      #2;
      chk("reset stall", int'(stall_iss_o), 0);
      chk("reset ex_valid", int'(ex_valid_o), 0);
      chk("reset fwd_p1", int'(fwd_p1_ex_o), 0);
      chk("reset fwd_p2", int'(fwd_p2_ex_o), 0);
      chk("reset inflight", int'(inflight_cnt_o), 0);
      chk("reset stall_cnt", int'(stall_cnt_o), 0);
      #10 reset = 1'b1;
      @(posedge clk);
      #1;

      // ALU back-to-back: add r3,r1,r2 ; sub r4,r3,r1
      issue("add_r3", 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 0);
      issue("sub_r4", 5'd3, 5'd1, 1, 1, 5'd4, 1, 0, 1, 0, 0);
      nop(4);
      chk("drained inflight", int'(inflight_cnt_o), 0);

      // Load-use: lw r5 ; add r6,r5,r5
      issue("lw_r5", 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 0);
      issue("add_r6", 5'd5, 5'd5, 1, 1, 5'd6, 1, 0, 2, 2, 1);
      chk("load-use stall_cnt", int'(stall_cnt_o), 1);
      nop(4);

      // Distance sweep on r7: 2 -> 2, 3 -> 3, 4 -> regfile
      for (int d = 2; d <= 4; d++) begin
         issue($sformatf("prod_r7_d%0d", d), 5'd0, 5'd0, 0, 0, 5'd7, 1, 0, 0, 0, 0);
         nop(d - 1);
         issue($sformatf("cons_r7_d%0d", d), 5'd7, 5'd0, 1, 0, 5'd8, 0, 0,
               (d == 4) ? 0 : d, 0, 0);
         nop(4);
      end

      // Youngest of two r3 producers wins
      issue("old_r3", 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 0, 0);
      issue("new_r3", 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 0, 0);
      issue("use_r3", 5'd0, 5'd3, 1, 1, 5'd9, 1, 0, 0, 1, 0);
      nop(4);

      // A load into r0 is never tracked
      issue("lw_r0", 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 0, 0);
      issue("use_r0", 5'd0, 5'd0, 1, 1, 5'd10, 1, 0, 0, 0, 0);
      nop(4);

      // Flush beats the load-use stall
      issue("lw_r5_fl", 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0, 0);
      iss_valid = 1'b1; iss_rs = 5'd5; iss_rt = 5'd5; iss_use_rs = 1'b1; iss_use_rt = 1'b1;
      iss_rd = 5'd6; iss_reg_wr = 1'b1; iss_is_load = 1'b0; flush = 1'b1;
      @(negedge clk);
      chk("flush stall", int'(stall_iss_o), 0);
      chk("flush inflight before", int'(inflight_cnt_o), 1);
      @(posedge clk);
      #1;
      iss_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush ex_valid", int'(ex_valid_o), 0);
      chk("flush fwd_p1", int'(fwd_p1_ex_o), 0);
      chk("flush inflight after", int'(inflight_cnt_o), 1);
      chk("flush stall_cnt", int'(stall_cnt_o), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("flush drained", int'(inflight_cnt_o), 0);
      $display("flush case checked");

      // Reset during a stall with three entries valid
      issue("a_r1", 5'd0, 5'd0, 0, 0, 5'd1, 1, 0, 0, 0, 0);
      issue("b_r2", 5'd0, 5'd0, 0, 0, 5'd2, 1, 0, 0, 0, 0);
      issue("lw_r5_rs", 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0, 0);
      iss_valid = 1'b1; iss_rs = 5'd5; iss_rt = 5'd1; iss_use_rs = 1'b1; iss_use_rt = 1'b0;
      iss_rd = 5'd11; iss_reg_wr = 1'b1; iss_is_load = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("pre-reset stall", int'(stall_iss_o), 1);
      chk("pre-reset inflight", int'(inflight_cnt_o), 3);
      #2 reset = 1'b0;
      #1;
      chk("async reset stall", int'(stall_iss_o), 0);
      chk("async reset ex_valid", int'(ex_valid_o), 0);
      chk("async reset fwd_p1", int'(fwd_p1_ex_o), 0);
      chk("async reset fwd_p2", int'(fwd_p2_ex_o), 0);
      chk("async reset inflight", int'(inflight_cnt_o), 0);
      chk("async reset stall_cnt", int'(stall_cnt_o), 0);
      @(posedge clk);
      #1;
      chk("held reset inflight", int'(inflight_cnt_o), 0);
      iss_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      issue("post_reset_use_r5", 5'd5, 5'd1, 1, 1, 5'd12, 1, 0, 0, 0, 0);
      nop(4);

      chk("pending expectations", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
